m_led_matrix_scan: RTL and testbench

Column-multiplexed scanner for the 10-row LED matrix: the reader side of the font ROM interface. It generates ROM column addresses, registers the returned 10-bit column pattern onto the row drivers, and asserts one column strobe at a time with a blanking gap between columns. It advances a scroll offset every N frames. It sits between the font ROM (combinational, address in / data out) and the matrix pins at the top level.

---
 rtl/led_matrix_pkg.sv | 23 ++
 rtl/m_scan_phase_cnt.sv | 29 ++
 rtl/m_led_matrix_scan.sv | 134 +++++++++++++
 tb/tb_m_led_matrix_scan.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the LED matrix column scanner.
package led_matrix_pkg;

    localparam int unsigned ROM_AW        = 6;
    localparam int unsigned ROW_W         = 10;
    localparam int unsigned DEF_CLK_DIV   = 25000;
    localparam int unsigned DEF_BLANK_CYC = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // Phase counter width: enough to hold the longer of the two reload values.
    function automatic int unsigned phase_width(input int unsigned clk_div,
                                                input int unsigned blank_cyc);
        int unsigned m;
        m = (clk_div > blank_cyc) ? clk_div : blank_cyc;
        return (m > 1) ? int'($clog2(m)) : 1;
    endfunction

endpackage

// File: rtl/m_scan_phase_cnt.sv
// Loadable down-counter timing the BLANK and SHOW phases; tc_c flags zero.
module m_scan_phase_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc_c = (cnt == '0);

endmodule

// File: rtl/m_led_matrix_scan.sv
// Column-multiplexed LED matrix scanner: reads font ROM columns, strobes one
// column at a time with a blanking gap, and advances a scroll offset.
module m_led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int unsigned CLK_DIV       = DEF_CLK_DIV,
    parameter int unsigned BLANK_CYC     = DEF_BLANK_CYC,
    parameter int unsigned N_COLS        = 8,
    parameter int unsigned SCROLL_FRAMES = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ROM_AW-1:0] radr,
    input  logic [ROW_W-1:0]  dat,
    output logic [N_COLS-1:0] col_sel,
    output logic [ROW_W-1:0]  row_dat,
    output logic              frame_tick,
    output logic [ROM_AW-1:0] scroll_ofs
);

    localparam int unsigned PH_W  = phase_width(CLK_DIV, BLANK_CYC);
    localparam int unsigned COL_W = $clog2(N_COLS);
    localparam int unsigned FRM_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [PH_W-1:0]   BLANK_LOAD = PH_W'(BLANK_CYC - 1);
    localparam logic [PH_W-1:0]   SHOW_LOAD  = PH_W'(CLK_DIV - 1);
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(N_COLS - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST   = FRM_W'(SCROLL_FRAMES - 1);
    localparam logic [N_COLS-1:0] COL_ONE    = N_COLS'(1);

    scan_state_t       state;
    logic [COL_W-1:0]  col;
    logic [FRM_W-1:0]  frm_cnt;

    logic              ph_tc;
    logic              ph_clr;
    logic              ph_load;
    logic [PH_W-1:0]   ph_val;

    logic [COL_W-1:0]  col_nxt;
    logic              scroll_step;
    logic [ROM_AW-1:0] ofs_nxt;

    m_scan_phase_cnt #(
        .W (PH_W)
    ) u_phase (
        .clk      (clk),
        .rst      (rst),
        .clr      (ph_clr),
        .load     (ph_load),
        .load_val (ph_val),
        .tc_c     (ph_tc)
    );

    // Next column / offset as seen by the BLANK phase that follows a SHOW exit.
    assign col_nxt     = (col == LAST_COL) ? '0 : col + COL_W'(1);
    assign scroll_step = (SCROLL_FRAMES != 0) && (col == LAST_COL) && (frm_cnt == FRM_LAST);
    assign ofs_nxt     = scroll_step ? scroll_ofs + ROM_AW'(1) : scroll_ofs;

    // Phase counter reloads on every state change; cleared while disabled.
    always_comb begin
        ph_clr  = 1'b0;
        ph_load = 1'b0;
        ph_val  = BLANK_LOAD;
        if (!en) begin
            ph_clr = 1'b1;
        end else begin
            case (state)
                ST_IDLE:  ph_load = 1'b1;
                ST_BLANK: begin
                    if (ph_tc) begin
                        ph_load = 1'b1;
                        ph_val  = SHOW_LOAD;
                    end
                end
                ST_SHOW:  ph_load = ph_tc;
                default:  ph_load = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            col        <= '0;
            frm_cnt    <= '0;
            radr       <= '0;
            col_sel    <= '0;
            row_dat    <= '0;
            frame_tick <= 1'b0;
            scroll_ofs <= '0;
        end else if (!en) begin
            // scroll_ofs deliberately held so a re-enable resumes in place
            state      <= ST_IDLE;
            col        <= '0;
            frm_cnt    <= '0;
            radr       <= '0;
            col_sel    <= '0;
            row_dat    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state <= ST_BLANK;
                    radr  <= scroll_ofs;
                end
                ST_BLANK: begin
                    if (ph_tc) begin
                        state   <= ST_SHOW;
                        row_dat <= dat;
                        col_sel <= COL_ONE << col;
                    end
                end
                ST_SHOW: begin
                    if (ph_tc) begin
                        state   <= ST_BLANK;
                        col_sel <= '0;
                        col     <= col_nxt;
                        radr    <= ofs_nxt + ROM_AW'(col_nxt);
                        if (col == LAST_COL) begin
                            frame_tick <= 1'b1;
                            frm_cnt    <= scroll_step ? '0 : frm_cnt + FRM_W'(1);
                            scroll_ofs <= ofs_nxt;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_led_matrix_scan.sv
// Scoreboard bench for m_led_matrix_scan with a small font ROM attached.
module tb_m_led_matrix_scan;

    typedef struct {
        int          at;
        logic [7:0]  sel;
        logic [9:0]  row;
        logic [5:0]  ofs;
    } col_exp_t;

    typedef struct {
        string name;
        int    at;
        int    sel;
        int    row;
        int    adr;
        int    ofs;
        int    ticks;
        bit    drain;
    } probe_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [5:0] radr;
    logic [9:0] dat;
    logic [7:0] col_sel;
    logic [9:0] row_dat;
    logic       frame_tick;
    logic [5:0] scroll_ofs;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int tick_cnt = 0;

    col_exp_t col_q[$];
    probe_t   probe_q[$];

    function automatic logic [9:0] font(input logic [5:0] a);
        case (a)
            6'd3:    return 10'h1ff;
            6'd4:    return 10'h010;
            6'd20:   return 10'h2aa;
            6'd63:   return 10'h3c0;
            default: return 10'h000;
        endcase
    endfunction

    assign dat = font(radr);

    m_led_matrix_scan #(
        .CLK_DIV       (4),
        .BLANK_CYC     (2),
        .N_COLS        (8),
        .SCROLL_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .radr       (radr),
        .dat        (dat),
        .col_sel    (col_sel),
        .row_dat    (row_dat),
        .frame_tick (frame_tick),
        .scroll_ofs (scroll_ofs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish by t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Expected column strobes: col c of frame f rises 3+48f+6c edges after enable.
    task automatic push_run(input int b, input int ofs0, input int nfull, input int ntail);
        col_exp_t e;
        int o;
        for (int f = 0; f <= nfull; f++) begin
            for (int c = 0; c < 8; c++) begin
                if (!(f == nfull && c >= ntail)) begin
                    o     = (ofs0 + f / 2) % 64;
                    e.at  = b + 3 + 48 * f + 6 * c;
                    e.sel = 8'h01 << c;
                    e.ofs = 6'(o);
                    e.row = font(6'(o + c));
                    col_q.push_back(e);
                end
            end
        end
    endtask

    task automatic add_probe(input string nm, input int at, input int sel, input int row,
                             input int adr, input int ofs, input int ticks, input bit drain);
        probe_t p;
        p.name = nm; p.at = at; p.sel = sel; p.row = row;
        p.adr = adr; p.ofs = ofs; p.ticks = ticks; p.drain = drain;
        probe_q.push_back(p);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every comparison is made here, at negedge or just after a reset rise.
    initial begin : monitor
        logic [7:0] prev_sel = '0;
        logic [9:0] prev_row = '0;
        logic       rst_d = 1'b1;
        bit         tick_ok = 1'b0;
        int         last_tick = 0;
        int         c0;
        col_exp_t   e;
        probe_t     p;
        bit         ok;
        forever begin
            @(negedge clk or posedge rst);
            if (rst && !rst_d) begin
                c0 = cyc;
                #1;
                total++;
                if (col_sel !== 8'h00 || row_dat !== 10'h000 || scroll_ofs !== 6'd0 || cyc != c0) begin
                    bad++;
                    $display("FAIL async_rst: col_sel=%h row_dat=%h scroll_ofs=%0d edges=%0d, want 0/0/0 with no clk edge",
                             col_sel, row_dat, scroll_ofs, cyc - c0);
                end
            end else begin
                if (rst || !en) tick_ok = 1'b0;
                if (!rst) begin
                    total++;
                    if ($countones(col_sel) > 1) begin
                        bad++;
                        $display("FAIL one_hot @%0d: col_sel=%b, want at most one bit", cyc, col_sel);
                    end
                    if (prev_sel != 8'h00 && col_sel != 8'h00) begin
                        total++;
                        if (col_sel !== prev_sel || row_dat !== prev_row) begin
                            bad++;
                            $display("FAIL show_hold @%0d: col_sel=%h row_dat=%h, want %h %h",
                                     cyc, col_sel, row_dat, prev_sel, prev_row);
                        end
                    end
                    if (prev_sel == 8'h00 && col_sel != 8'h00) begin
                        total++;
                        if (col_q.size() == 0) begin
                            bad++;
                            $display("FAIL col_evt @%0d: unexpected col_sel=%h row_dat=%h, want no strobe",
                                     cyc, col_sel, row_dat);
                        end else begin
                            e = col_q.pop_front();
                            if (e.at != cyc || col_sel !== e.sel || row_dat !== e.row || scroll_ofs !== e.ofs) begin
                                bad++;
                                $display("FAIL col_evt @%0d: col_sel=%h row_dat=%h ofs=%0d, want @%0d %h %h ofs=%0d",
                                         cyc, col_sel, row_dat, scroll_ofs, e.at, e.sel, e.row, e.ofs);
                            end
                        end
                    end
                    if (frame_tick) begin
                        tick_cnt++;
                        total++;
                        if (col_sel !== 8'h00) begin
                            bad++;
                            $display("FAIL tick_blank @%0d: col_sel=%h, want 00", cyc, col_sel);
                        end
                        if (tick_ok) begin
                            total++;
                            if (cyc - last_tick != 48) begin
                                bad++;
                                $display("FAIL tick_period @%0d: spacing=%0d, want 48", cyc, cyc - last_tick);
                            end
                        end
                        last_tick = cyc;
                        tick_ok   = 1'b1;
                    end
                end
                prev_sel = col_sel;
                prev_row = row_dat;
                for (int i = int'(probe_q.size()) - 1; i >= 0; i--) begin
                    if (probe_q[i].at <= cyc) begin
                        p = probe_q[i];
                        probe_q.delete(i);
                        total++;
                        ok = (p.at == cyc)
                          && (p.sel   < 0 || col_sel    === 8'(p.sel))
                          && (p.row   < 0 || row_dat    === 10'(p.row))
                          && (p.adr   < 0 || radr       === 6'(p.adr))
                          && (p.ofs   < 0 || scroll_ofs === 6'(p.ofs))
                          && (p.ticks < 0 || tick_cnt   == p.ticks)
                          && (!p.drain || col_q.size() == 0);
                        if (!ok) begin
                            bad++;
                            $display("FAIL %s @%0d: col_sel=%h row_dat=%h radr=%0d ofs=%0d ticks=%0d pend=%0d, want @%0d sel=%0d row=%0d adr=%0d ofs=%0d ticks=%0d drain=%0d (-1 = any)",
                                     p.name, cyc, col_sel, row_dat, radr, scroll_ofs, tick_cnt, col_q.size(),
                                     p.at, p.sel, p.row, p.adr, p.ofs, p.ticks, p.drain);
                        end
                    end
                end
            end
            rst_d = rst;
        end
    end

    // Stimulus: drives en/rst at negedge and queues expected responses.
    initial begin : stimulus
        int base;
        int base2;
        repeat (2) @(negedge clk);
        add_probe("rst_state", cyc + 1, 0, 0, 0, 0, 0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        en   = 1'b1;
        base = cyc;
        push_run(base, 0, 131, 6);
        add_probe("en_blank0",  base + 1,    0, -1, 0, 0, -1, 1'b0);
        add_probe("blank_hold", base + 2,    0, -1, 0, -1, -1, 1'b0);
        add_probe("col0_on",    base + 3,    1, 0, -1, 0, -1, 1'b0);
        add_probe("col0_last",  base + 6,    1, 0, -1, -1, -1, 1'b0);
        add_probe("col0_off",   base + 7,    0, -1, 1, 0, 0, 1'b0);
        add_probe("f0_col3",    base + 22,   8, 'h1ff, -1, 0, -1, 1'b0);
        add_probe("f0_col4",    base + 28,   16, 'h010, -1, 0, -1, 1'b0);
        add_probe("tick1",      base + 50,   0, -1, -1, 0, 1, 1'b0);
        add_probe("scroll1",    base + 98,   0, -1, 1, 1, 2, 1'b0);
        add_probe("f2_col2",    base + 112,  4, 'h1ff, -1, 1, -1, 1'b0);
        add_probe("f2_col3",    base + 118,  8, 'h010, -1, 1, -1, 1'b0);
        add_probe("wrap63",     base + 6099, 1, 'h3c0, -1, 63, -1, 1'b0);
        add_probe("adr_mod",    base + 6104, 0, -1, 0, 63, -1, 1'b0);
        add_probe("wrap0_adr",  base + 6146, 0, -1, 0, 0, 128, 1'b0);
        add_probe("wrap0_col3", base + 6166, 8, 'h1ff, -1, 0, -1, 1'b0);
        add_probe("dis_off",    base + 6322, 0, 0, 0, 1, 131, 1'b0);
        add_probe("dis_drain",  base + 6323, 0, 0, 0, 1, 131, 1'b1);

        // col 5 of frame 131 rises at edge 6321; drop en during its SHOW
        wait_cyc(base + 6321);
        en = 1'b0;

        wait_cyc(base + 6326);
        en    = 1'b1;
        base2 = cyc;
        push_run(base2, 1, 2, 3);
        add_probe("re_blank", base2 + 1,   0, -1, 1, 1, -1, 1'b0);
        add_probe("re_col0",  base2 + 3,   1, 0, -1, 1, -1, 1'b0);
        add_probe("re_ticks", base2 + 110, 0, -1, -1, 2, 133, 1'b0);
        add_probe("re_col2",  base2 + 111, 4, 'h010, -1, 2, -1, 1'b0);

        wait_cyc(base2 + 112);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        add_probe("post_rst", cyc + 2, 0, 0, 0, 0, 133, 1'b1);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
